// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display update path.
// Used by the update sequencer and by lcd_write_responder.
//   update_t    : sequencer state, 3 bits
//   INIT_LENGTH : words in the init-command sequence
//   PIX_LEN     : words per pixel sequence (RAMWR command + pixel bytes)
//   RAMWR_CMD   : command byte opening every pixel sequence
package display_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_I  = 3'd1,
    SET    = 3'd2,
    SEND_I = 3'd3,
    SEND   = 3'd4,
    DONE   = 3'd5
  } update_t;

  localparam int          INIT_LENGTH = 40;
  localparam int          PIX_LEN     = 811;
  localparam logic [7:0]  RAMWR_CMD   = 8'h2C;

  // Lengths as 10-bit constants so word_idx compares stay width-matched.
  localparam logic [9:0]  INIT_LEN_W  = 10'(INIT_LENGTH);
  localparam logic [9:0]  PIX_LEN_W   = 10'(PIX_LEN);

  function automatic logic is_init_mode(update_t m);
    return (m == SET_I) || (m == SEND_I);
  endfunction

  function automatic logic is_pixel_mode(update_t m);
    return (m == SET) || (m == SEND);
  endfunction

endpackage

// File: rtl/lcd_write_responder_if.sv
// lcd_write_responder_if: sequencer handshake plus LCD 8080 write bus.
//   master : sequencer/frame-source side (drives mode, enable, wr, pix_in)
//   slave  : lcd_write_responder (drives pix_rd, cmd_finished, LCD pins, word_idx)
interface lcd_write_responder_if;
  import display_pkg::*;

  update_t     mode;
  logic        enable;
  logic        wr;
  logic [7:0]  pix_in;
  logic        pix_rd;
  logic        cmd_finished;
  logic [7:0]  lcd_data;
  logic        lcd_dcx;
  logic        lcd_wrx;
  logic        lcd_csx;
  logic [9:0]  word_idx;

  modport master (
    output mode, enable, wr, pix_in,
    input  pix_rd, cmd_finished, lcd_data, lcd_dcx, lcd_wrx, lcd_csx, word_idx
  );

  modport slave (
    input  mode, enable, wr, pix_in,
    output pix_rd, cmd_finished, lcd_data, lcd_dcx, lcd_wrx, lcd_csx, word_idx
  );

endinterface

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: combinational init-command table, INIT_LENGTH x 9 bits.
//   idx  : word index (10 bits); indices past the table return 0
//   word : {dcx, byte}, dcx=0 for a command, 1 for a parameter byte
module lcd_init_rom
  import display_pkg::*;
(
  input  logic [9:0] idx,
  output logic [8:0] word
);

  always_comb begin
    word = 9'h000;
    case (idx)
      10'd0:  word = {1'b0, 8'h01};  // SWRESET
      10'd1:  word = {1'b0, 8'h11};  // SLPOUT
      10'd2:  word = {1'b0, 8'h3A};  // COLMOD
      10'd3:  word = {1'b1, 8'h55};
      10'd4:  word = {1'b0, 8'h36};  // MADCTL
      10'd5:  word = {1'b1, 8'h00};
      10'd6:  word = {1'b0, 8'h2A};  // CASET
      10'd7:  word = {1'b1, 8'h00};
      10'd8:  word = {1'b1, 8'h00};
      10'd9:  word = {1'b1, 8'h00};
      10'd10: word = {1'b1, 8'hEF};
      10'd11: word = {1'b0, 8'h2B};  // RASET
      10'd12: word = {1'b1, 8'h00};
      10'd13: word = {1'b1, 8'h00};
      10'd14: word = {1'b1, 8'h01};
      10'd15: word = {1'b1, 8'h3F};
      10'd16: word = {1'b0, 8'hB2};  // PORCTRL
      10'd17: word = {1'b1, 8'h0C};
      10'd18: word = {1'b1, 8'h0C};
      10'd19: word = {1'b1, 8'h00};
      10'd20: word = {1'b1, 8'h33};
      10'd21: word = {1'b1, 8'h33};
      10'd22: word = {1'b0, 8'hB7};  // GCTRL
      10'd23: word = {1'b1, 8'h35};
      10'd24: word = {1'b0, 8'hBB};  // VCOMS
      10'd25: word = {1'b1, 8'h19};
      10'd26: word = {1'b0, 8'hC0};  // LCMCTRL
      10'd27: word = {1'b1, 8'h2C};
      10'd28: word = {1'b0, 8'hC2};  // VDVVRHEN
      10'd29: word = {1'b1, 8'h01};
      10'd30: word = {1'b0, 8'hC3};  // VRHS
      10'd31: word = {1'b1, 8'h12};
      10'd32: word = {1'b0, 8'hC4};  // VDVS
      10'd33: word = {1'b1, 8'h20};
      10'd34: word = {1'b0, 8'hC6};  // FRCTRL2
      10'd35: word = {1'b1, 8'h0F};
      10'd36: word = {1'b0, 8'h21};  // INVON
      10'd37: word = {1'b0, 8'h13};  // NORON
      10'd38: word = {1'b0, 8'h29};  // DISPON
      10'd39: word = {1'b0, 8'h00};  // NOP
      default: word = 9'h000;
    endcase
  end

endmodule

// File: rtl/lcd_write_responder.sv
// lcd_write_responder: answers the update sequencer's enable/wr strobes and
// drives the 8080-style LCD write bus from the init ROM or the pixel stream.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : lcd_write_responder_if.slave (mode/enable/wr/pix_in in;
//               pix_rd, cmd_finished, lcd_data/dcx/wrx/csx, word_idx out)
module lcd_write_responder
  import display_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  lcd_write_responder_if.slave   bus
);

  update_t     mode;
  logic        init_seq;
  logic        set_phase;
  logic        send_phase;
  logic        clear;
  logic        load;
  logic [9:0]  len;
  logic [8:0]  rom_word;

  logic [7:0]  data_q;
  logic        dcx_q;
  logic        wrx_q;
  logic        csx_q;
  logic        fin_q;
  logic [9:0]  idx_q;

  assign mode       = bus.mode;
  assign init_seq   = is_init_mode(mode);
  assign len        = init_seq ? INIT_LEN_W : PIX_LEN_W;
  assign set_phase  = (mode == SET_I) || (mode == SET);
  assign send_phase = (mode == SEND_I) || (mode == SEND);
  assign clear      = (mode == IDLE) || (mode == DONE);

  // The idx < len guard makes word_idx saturate at LEN and turns an
  // overrun enable into a no-op (no load, no pix_rd).
  assign load = bus.enable && set_phase && (idx_q < len);

  // Word 0 of a pixel sequence is RAMWR, so no pixel byte is consumed there.
  assign bus.pix_rd = load && (mode == SET) && (idx_q != 10'd0);

  lcd_init_rom u_rom (
    .idx  (idx_q),
    .word (rom_word)
  );

  // A load pulls wrx low on the same edge the data changes; wr raises it
  // one edge later. Data is only replaced by the next load, so it holds a
  // full cycle past the wrx rising edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q <= 8'h00;
      dcx_q  <= 1'b1;
      wrx_q  <= 1'b1;
      csx_q  <= 1'b1;
      fin_q  <= 1'b0;
      idx_q  <= 10'd0;
    end else begin
      csx_q <= (mode == IDLE);
      if (clear) begin
        idx_q <= 10'd0;
        fin_q <= 1'b0;
      end else if (load) begin
        if (init_seq) begin
          {dcx_q, data_q} <= rom_word;
        end else if (idx_q == 10'd0) begin
          data_q <= RAMWR_CMD;
          dcx_q  <= 1'b0;
        end else begin
          data_q <= bus.pix_in;
          dcx_q  <= 1'b1;
        end
        idx_q <= idx_q + 10'd1;
        wrx_q <= 1'b0;
        if (idx_q == len - 10'd1) fin_q <= 1'b1;
      end else if (bus.wr && send_phase) begin
        wrx_q <= 1'b1;
      end
    end
  end

  assign bus.lcd_data     = data_q;
  assign bus.lcd_dcx      = dcx_q;
  assign bus.lcd_wrx      = wrx_q;
  assign bus.lcd_csx      = csx_q;
  assign bus.cmd_finished = fin_q;
  assign bus.word_idx     = idx_q;

  // Protocol checks: the sequencer must never strobe enable and wr together,
  // and must pass through IDLE/DONE when switching between init and pixel.
  a_no_enable_with_wr: assert property (
    @(posedge clk) disable iff (!nrst) !(bus.enable && bus.wr));

  a_no_family_switch: assert property (
    @(posedge clk) disable iff (!nrst)
      !((is_init_mode($past(mode)) && is_pixel_mode(mode)) ||
        (is_pixel_mode($past(mode)) && is_init_mode(mode))));

endmodule

// File: tb/tb_lcd_write_responder.sv
// tb_lcd_write_responder: self-checking bench for lcd_write_responder.
// Expected words come from a reference table of the init sequence and the
// pixel-sequence rule (RAMWR first, then the offered pixel bytes).
module tb_lcd_write_responder;
  import display_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  lcd_write_responder_if bus ();

  lcd_write_responder dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int pix_pulses = 0;

  // Reference init sequence as {dcx, byte}.
  logic [8:0] init_table [INIT_LENGTH] = '{
    9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h02A, 9'h100,
    9'h100, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F,
    9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133, 9'h0B7, 9'h135,
    9'h0BB, 9'h119, 9'h0C0, 9'h12C, 9'h0C2, 9'h101, 9'h0C3, 9'h112,
    9'h0C4, 9'h120, 9'h0C6, 9'h10F, 9'h021, 9'h013, 9'h029, 9'h000
  };

  always @(posedge clk) if (bus.pix_rd) pix_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a new input set just after a falling edge.
  task automatic applyStimulus(input update_t m, input logic en, input logic w,
                               input logic [7:0] pix);
    @(negedge clk);
    bus.mode   = m;
    bus.enable = en;
    bus.wr     = w;
    bus.pix_in = pix;
  endtask

  // Runs `words` enable/wr pairs of one sequence, checking every word
  // against the reference sequence.
  task automatic runSequence(input bit init_seq, input int words);
    int         len;
    update_t    set_m, send_m;
    logic [7:0] pix;
    logic [8:0] exp_w;
    len    = init_seq ? INIT_LENGTH : PIX_LEN;
    set_m  = init_seq ? SET_I : SET;
    send_m = init_seq ? SEND_I : SEND;
    for (int k = 0; k < words; k++) begin
      pix = (k == 1) ? 8'hA5 : 8'($urandom);
      applyStimulus(set_m, 1'b1, 1'b0, pix);
      #1 checkOutput("pix_rd", 32'(bus.pix_rd), 32'(!init_seq && k > 0));
      @(posedge clk); #1;
      if (init_seq)    exp_w = init_table[k];
      else if (k == 0) exp_w = {1'b0, RAMWR_CMD};
      else             exp_w = {1'b1, pix};
      checkOutput("lcd_data", 32'(bus.lcd_data), 32'(exp_w[7:0]));
      checkOutput("lcd_dcx", 32'(bus.lcd_dcx), 32'(exp_w[8]));
      checkOutput("wrx_low", 32'(bus.lcd_wrx), 32'd0);
      checkOutput("word_idx", 32'(bus.word_idx), 32'(k + 1));
      checkOutput("cmd_finished", 32'(bus.cmd_finished), 32'(k + 1 == len));
      checkOutput("csx_low", 32'(bus.lcd_csx), 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        // wr while still in the SET phase must not release wrx
        applyStimulus(set_m, 1'b0, 1'b1, 8'($urandom));
        @(posedge clk); #1;
        checkOutput("wr_in_set_ignored", 32'(bus.lcd_wrx), 32'd0);
      end
      applyStimulus(send_m, 1'b0, 1'b1, 8'($urandom));
      @(posedge clk); #1;
      checkOutput("wrx_high", 32'(bus.lcd_wrx), 32'd1);
      checkOutput("data_hold", 32'(bus.lcd_data), 32'(exp_w[7:0]));
      checkOutput("fin_in_send", 32'(bus.cmd_finished), 32'(k + 1 == len));
      if (k % 100 == 0) begin
        // enable outside the SET phase must not load a word
        applyStimulus(send_m, 1'b1, 1'b0, 8'($urandom));
        #1 checkOutput("enable_in_send_pix_rd", 32'(bus.pix_rd), 32'd0);
        @(posedge clk); #1;
        checkOutput("enable_in_send_idx", 32'(bus.word_idx), 32'(k + 1));
        checkOutput("enable_in_send_wrx", 32'(bus.lcd_wrx), 32'd1);
      end
    end
  endtask

  initial begin
    int start_pulses;
    logic [7:0] last_data;

    bus.mode = IDLE; bus.enable = 1'b0; bus.wr = 1'b0; bus.pix_in = 8'h00;

    // Reset held with strobes toggling
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2) ? SEND : SET, ~i[0], i[0], 8'($urandom));
      @(posedge clk); #1;
      checkOutput("rst_wrx", 32'(bus.lcd_wrx), 32'd1);
      checkOutput("rst_csx", 32'(bus.lcd_csx), 32'd1);
      checkOutput("rst_fin", 32'(bus.cmd_finished), 32'd0);
      checkOutput("rst_idx", 32'(bus.word_idx), 32'd0);
    end
    checkOutput("rst_data", 32'(bus.lcd_data), 32'h00);
    checkOutput("rst_dcx", 32'(bus.lcd_dcx), 32'd1);
    checkOutput("rst_pix_rd_count", 32'(pix_pulses), 32'd0);
    applyStimulus(IDLE, 1'b0, 1'b0, 8'h00);
    nrst = 1'b1;
    applyStimulus(IDLE, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("idle_csx", 32'(bus.lcd_csx), 32'd1);

    // Full init sequence, then DONE clears
    runSequence(1'b1, INIT_LENGTH);
    checkOutput("init_no_pix_rd", 32'(pix_pulses), 32'd0);
    last_data = bus.lcd_data;
    applyStimulus(DONE, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("done_fin_clear", 32'(bus.cmd_finished), 32'd0);
    checkOutput("done_idx_clear", 32'(bus.word_idx), 32'd0);
    checkOutput("done_data_retained", 32'(bus.lcd_data), 32'(last_data));
    checkOutput("done_csx", 32'(bus.lcd_csx), 32'd0);
    applyStimulus(IDLE, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("idle_csx_high", 32'(bus.lcd_csx), 32'd1);

    // Full pixel sequence
    start_pulses = pix_pulses;
    runSequence(1'b0, PIX_LEN);
    checkOutput("pix_rd_pulses", 32'(pix_pulses - start_pulses), 32'(PIX_LEN - 1));

    // Overrun enable
    last_data = bus.lcd_data;
    applyStimulus(SET, 1'b1, 1'b0, 8'($urandom));
    #1 checkOutput("overrun_pix_rd", 32'(bus.pix_rd), 32'd0);
    @(posedge clk); #1;
    checkOutput("overrun_data", 32'(bus.lcd_data), 32'(last_data));
    checkOutput("overrun_idx", 32'(bus.word_idx), 32'(PIX_LEN));
    checkOutput("overrun_fin", 32'(bus.cmd_finished), 32'd1);
    checkOutput("overrun_wrx", 32'(bus.lcd_wrx), 32'd1);
    applyStimulus(DONE, 1'b0, 1'b0, 8'h00);
    applyStimulus(IDLE, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of pixel word 300
    runSequence(1'b0, 300);
    applyStimulus(SET, 1'b1, 1'b0, 8'($urandom));
    @(posedge clk); #1;
    checkOutput("mid_wrx_low", 32'(bus.lcd_wrx), 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    nrst = 1'b0;
    #1;
    checkOutput("mid_rst_wrx", 32'(bus.lcd_wrx), 32'd1);
    checkOutput("mid_rst_csx", 32'(bus.lcd_csx), 32'd1);
    checkOutput("mid_rst_idx", 32'(bus.word_idx), 32'd0);
    bus.mode = IDLE;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    applyStimulus(IDLE, 1'b0, 1'b0, 8'h00);
    runSequence(1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_write_responder.md
Name: lcd_write_responder

Overview:
- Sits on the other side of the display update handshake. It answers the update sequencer's enable/wr strobes and returns cmd_finished.
- Sources each word from either the init-command ROM or the pixel stream. It drives the 8080-style parallel write bus to the LCD (data, dcx, wrx, csx).
- One instance sits between the update sequencer and the LCD pins.

Parameters:
INIT_LENGTH, 40, number of words in the init sequence, held in the ROM as {dcx, byte}
PIX_LEN, 811, words per pixel sequence: word 0 is the RAMWR command, words 1..PIX_LEN-1 are pixel bytes
RAMWR_CMD, 8'h2C, command byte sent as word 0 of every pixel sequence

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
mode  input  3  update_t sequencer state (IDLE, SET_I, SET, SEND_I, SEND, DONE)
enable  input  1  one-cycle strobe: fetch the next word
wr  input  1  one-cycle strobe: complete the bus write of the current word
pix_in  input  8  current pixel byte from the frame source
pix_rd  output  1  one-cycle pulse: pix_in consumed, advance the source
cmd_finished  output  1  last word of the current sequence has been loaded
lcd_data  output  8  parallel bus data
lcd_dcx  output  1  0 = command, 1 = data
lcd_wrx  output  1  write strobe, active low; LCD latches on the rising edge
lcd_csx  output  1  chip select, active low
word_idx  output  10  index of the next word to load (debug/verification)

Behaviour:
- Reset values: lcd_data=0, lcd_dcx=1, lcd_wrx=1, lcd_csx=1, cmd_finished=0, pix_rd=0, word_idx=0. Reset mid-write releases wrx and csx immediately.
- Sequence select: mode in {SET_I, SEND_I} selects init (LEN=INIT_LENGTH); mode in {SET, SEND} selects pixel (LEN=PIX_LEN).
- Load happens on enable while mode is SET_I or SET, and word_idx < LEN. It is registered and visible the cycle after enable.
  - init: {lcd_dcx, lcd_data} <= rom[word_idx].
  - pixel, word_idx==0: lcd_data <= RAMWR_CMD, lcd_dcx <= 0.
  - pixel, word_idx>=1: lcd_data <= pix_in, lcd_dcx <= 1. pix_rd=1 in the enable cycle (combinational, exactly one pulse per consumed byte).
  - word_idx <= word_idx+1.
  - lcd_wrx <= 0.
  - cmd_finished <= 1 if word_idx == LEN-1.
- Write completion: on wr while mode is SEND_I or SEND, lcd_wrx <= 1.
  - Timing: data and wrx fall on the same edge. wrx rises one edge later. Data holds until the next enable edge, giving one full cycle of hold.
- cmd_finished is valid in the cycle the sequencer sits in SEND/SEND_I after the last load. It stays high until mode==DONE or IDLE.
- Clear: while mode is IDLE or DONE, word_idx <= 0 and cmd_finished <= 0 (registered). lcd_data and lcd_dcx retain their values.
- lcd_csx <= 0 whenever mode != IDLE; lcd_csx <= 1 in IDLE. lcd_csx is registered, so it lags mode by one cycle.
- Ignored strobes:
  - enable in any mode other than SET_I/SET has no effect.
  - enable when word_idx == LEN has no effect: no load, no pix_rd, and cmd_finished stays 1.
  - wr outside SEND_I/SEND has no effect.
- Simultaneous enable and wr: enable wins for lcd_wrx (stays 0) and the load proceeds. This is a protocol error; flag it with an assertion only.
- Width: word_idx is 10 bits and saturates at LEN, never wraps. LEN-1 compares use the 10-bit constant.
- Mode switching between init and pixel families without passing DONE/IDLE is illegal. The block does not reset word_idx in that case; cover it with an assertion.

Decomposition:
- Package display_pkg: update_t enum (3 bits, IDLE=0, SET_I=1, SET=2, SEND_I=3, SEND=4, DONE=5), INIT_LENGTH, PIX_LEN, RAMWR_CMD. The sequencer imports the same package.
- Sub-module lcd_init_rom: combinational 9-bit x INIT_LENGTH lookup indexed by word_idx, contents {dcx, byte}. Entry 0 = {0, 8'h01} SWRESET, entry 1 = {0, 8'h11} SLPOUT.

Test Plan:
- Reset: hold nrst=0 with enable/wr toggling -> lcd_wrx=1, lcd_csx=1, cmd_finished=0, word_idx=0, pix_rd never asserted.
- Init words: mode SET_I, enable; then SEND_I, wr -> edge+1: data=8'h01, dcx=0, wrx=0; edge+2: wrx=1. Second pair -> data=8'h11, word_idx=2.
- Init completion: 40 enable/wr pairs -> cmd_finished rises after the 40th enable; mode=DONE -> cmd_finished=0, word_idx=0 next edge.
- Pixel sequence: mode SET/SEND, pix_in=8'hA5 -> first word is data=8'h2C, dcx=0, no pix_rd; second word is data=8'hA5, dcx=1, pix_rd pulse; exactly 810 pix_rd pulses; cmd_finished after the 811th enable.
- Overrun: extra enable after word 811 -> no data change, no pix_rd, word_idx stays 811, cmd_finished=1.
- Reset mid-write: nrst low while wrx=0 in pixel word 300 -> wrx=1, csx=1 immediately; after release a new pixel sequence restarts at RAMWR (8'h2C).
